// File: rtl/pulp_reset_conditioner.sv
// Board reset conditioner: synchronises the reset button and JTAG TRST,
// debounces the button and stretches every issued reset to a minimum length.
module pulp_reset_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_reset_i,
    input  logic       jtag_trst_ni,
    output logic       reset_no,
    output logic [1:0] state_o,
    output logic [7:0] rst_count_o
);

    localparam int unsigned MAX_CYC =
        (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        DEBOUNCE = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] trst_sync_q;
    logic                   btn_s;
    logic                   trst_s;
    logic                   req;
    logic                   jreq;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             reset_q;
    logic [7:0]       rst_count_q;
    logic [7:0]       rst_count_d;

    // Reset values make both chains read as an active request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            btn_sync_q  <= '1;
            trst_sync_q <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_reset_i};
            trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], jtag_trst_ni};
        end
    end

    assign btn_s  = btn_sync_q[SYNC_STAGES-1];
    assign trst_s = trst_sync_q[SYNC_STAGES-1];
    assign jreq   = ~trst_s;
    assign req    = btn_s | jreq;

    assign rst_count_d = (rst_count_q == 8'hFF) ? rst_count_q
                                                : rst_count_q + 8'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            reset_q     <= 1'b0;
            rst_count_q <= '0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    reset_q <= 1'b0;
                    if (req) begin
                        cnt_q <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        reset_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (jreq) begin
                        state_q     <= HOLD;
                        cnt_q       <= '0;
                        reset_q     <= 1'b0;
                        rst_count_q <= rst_count_d;
                    end else if (btn_s) begin
                        state_q <= DEBOUNCE;
                        cnt_q   <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (jreq) begin
                        state_q     <= HOLD;
                        cnt_q       <= '0;
                        reset_q     <= 1'b0;
                        rst_count_q <= rst_count_d;
                    end else if (!btn_s) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q     <= HOLD;
                        cnt_q       <= '0;
                        reset_q     <= 1'b0;
                        rst_count_q <= rst_count_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // Illegal encoding: fall back to a fresh, uncounted hold.
                    state_q <= HOLD;
                    cnt_q   <= '0;
                    reset_q <= 1'b0;
                end
            endcase
        end
    end

    assign reset_no    = reset_q;
    assign state_o     = state_q;
    assign rst_count_o = rst_count_q;

endmodule
